// File: rtl/fetch_unit.sv
// Sequential instruction fetch: issues PC requests to an in-order cache, keeps
// in-flight PCs in a small FIFO and pairs each returned word with its PC.
package C;
  localparam int XLEN = 64;
endpackage

module fetch_unit #(
  parameter int              XLEN         = C::XLEN,
  parameter logic [XLEN-1:0] BOOT_ADDR    = XLEN'(64'h8000_0000),
  parameter int              MAX_INFLIGHT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fetch_addr_ready,
  output logic             fetch_addr_valid,
  output logic [XLEN-1:0]  fetch_addr,
  input  logic             fetch_data_valid,
  input  logic [31:0]      fetch_data,
  output logic             fetch_data_ready,
  output logic [XLEN+31:0] fetch_o,        // fetch_data_t {pc, instr}, pc in the upper bits
  output logic             fetch_o_valid,
  input  logic             fetch_o_ready
);
  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_data_t;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  pc_mem_q [MAX_INFLIGHT];
  fetch_data_t      out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop;

  // Both ready/valid outputs are forced low combinationally while rstn is low.
  assign fetch_addr_valid = rstn && (count_q < CNT_W'(MAX_INFLIGHT));
  assign fetch_addr       = pc_q;
  assign fetch_data_ready = rstn && (count_q != '0) && (!out_valid_q || fetch_o_ready);

  assign push = fetch_addr_valid && fetch_addr_ready;
  assign pop  = fetch_data_valid && fetch_data_ready;

  assign fetch_o       = out_q;
  assign fetch_o_valid = out_valid_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (push) begin
      pc_d   = pc_q + XLEN'(4);
      tail_d = tail_q + PTR_W'(1);
    end

    if (pop) begin
      head_d       = head_q + PTR_W'(1);
      out_d.pc     = pc_mem_q[head_q];
      out_d.instr  = fetch_data;
      out_valid_d  = 1'b1;
    end else if (fetch_o_ready) begin
      out_valid_d  = 1'b0;
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: state registers use non-blocking assignments; the comb block above uses blocking.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q        <= BOOT_ADDR;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: PC storage and output payload are not reset; count and valid qualify their contents.
  always_ff @(posedge clk) begin
    if (push) pc_mem_q[tail_q] <= pc_q;
    out_q <= out_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: streaming, backpressure on both
// sides, in-flight limit, mid-operation reset, empty-queue data and PC wrap.
module tb_fetch_unit;
  localparam logic [63:0] BASE      = 64'h8000_0000;
  localparam logic [63:0] WRAP_BOOT = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fetch_addr_ready = 1'b0;
  logic        fetch_data_valid = 1'b0;
  logic [31:0] fetch_data = '0;
  logic        fetch_o_ready = 1'b0;

  logic        fetch_addr_valid, fetch_data_ready, fetch_o_valid;
  logic [63:0] fetch_addr;
  logic [95:0] fetch_o;

  logic        w_addr_valid, w_data_ready, w_fo_valid;
  logic [63:0] w_addr;
  logic [95:0] w_fo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rstn(rstn),
    .fetch_addr_ready(fetch_addr_ready), .fetch_addr_valid(fetch_addr_valid),
    .fetch_addr(fetch_addr),
    .fetch_data_valid(fetch_data_valid), .fetch_data(fetch_data),
    .fetch_data_ready(fetch_data_ready),
    .fetch_o(fetch_o), .fetch_o_valid(fetch_o_valid), .fetch_o_ready(fetch_o_ready)
  );

  fetch_unit #(.BOOT_ADDR(WRAP_BOOT)) dut_wrap (
    .clk(clk), .rstn(rstn),
    .fetch_addr_ready(fetch_addr_ready), .fetch_addr_valid(w_addr_valid),
    .fetch_addr(w_addr),
    .fetch_data_valid(fetch_data_valid), .fetch_data(fetch_data),
    .fetch_data_ready(w_data_ready),
    .fetch_o(w_fo), .fetch_o_valid(w_fo_valid), .fetch_o_ready(fetch_o_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds rstn low across one rising edge, then releases it; returns in cycle 0.
  task automatic apply_reset();
    rstn = 1'b0;
    fetch_addr_ready = 1'b0;
    fetch_data_valid = 1'b0;
    fetch_data = '0;
    fetch_o_ready = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    fetch_addr_ready = 1'b1;
    fetch_data_valid = 1'b1;
    #1;
    checks++;
    if (fetch_addr_valid !== 1'b0) begin
      failures++; $display("FAIL reset_addr_valid: got %b expected 0", fetch_addr_valid);
    end
    checks++;
    if (fetch_data_ready !== 1'b0) begin
      failures++; $display("FAIL reset_data_ready: got %b expected 0", fetch_data_ready);
    end
    tick();
    checks++;
    if (fetch_o_valid !== 1'b0) begin
      failures++; $display("FAIL reset_fo_valid: got %b expected 0", fetch_o_valid);
    end
    rstn = 1'b1;
    fetch_addr_ready = 1'b0;
    fetch_data_valid = 1'b0;
    #1;
    checks++;
    if (fetch_addr_valid !== 1'b1 || fetch_addr !== BASE) begin
      failures++;
      $display("FAIL reset_first_addr: got valid=%b addr=%h expected valid=1 addr=%h",
               fetch_addr_valid, fetch_addr, BASE);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    fetch_addr_ready = 1'b1;
    fetch_o_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      fetch_data_valid = (cyc >= 1);
      fetch_data = 32'(32'h13 + cyc - 1);
      #1;
      checks++;
      if (fetch_addr_valid !== 1'b1 || fetch_addr !== BASE + 64'(4 * cyc)) begin
        failures++;
        $display("FAIL stream_addr c%0d: got valid=%b addr=%h expected valid=1 addr=%h",
                 cyc, fetch_addr_valid, fetch_addr, BASE + 64'(4 * cyc));
      end
      checks++;
      if (fetch_data_ready !== (cyc >= 1)) begin
        failures++;
        $display("FAIL stream_data_ready c%0d: got %b expected %b", cyc, fetch_data_ready, cyc >= 1);
      end
      checks++;
      if (cyc >= 2) begin
        if (fetch_o_valid !== 1'b1 || fetch_o[95:32] !== BASE + 64'(4 * (cyc - 2)) ||
            fetch_o[31:0] !== 32'(32'h13 + cyc - 2)) begin
          failures++;
          $display("FAIL stream_fo c%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                   cyc, fetch_o_valid, fetch_o[95:32], fetch_o[31:0],
                   BASE + 64'(4 * (cyc - 2)), 32'(32'h13 + cyc - 2));
        end
      end else if (fetch_o_valid !== 1'b0) begin
        failures++;
        $display("FAIL stream_fo_idle c%0d: got valid=%b expected 0", cyc, fetch_o_valid);
      end
      tick();
    end
    fetch_data_valid = 1'b0;
    fetch_o_ready = 1'b0;
  endtask

  task automatic test_no_response();
    apply_reset();
    fetch_addr_ready = 1'b1;
    fetch_o_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      checks++;
      if (fetch_addr_valid !== (cyc < 4) || fetch_addr !== BASE + 64'(4 * (cyc < 4 ? cyc : 4))) begin
        failures++;
        $display("FAIL inflight_limit c%0d: got valid=%b addr=%h expected valid=%b addr=%h",
                 cyc, fetch_addr_valid, fetch_addr, cyc < 4, BASE + 64'(4 * (cyc < 4 ? cyc : 4)));
      end
      tick();
    end
    checks++;
    if (fetch_data_ready !== 1'b1) begin
      failures++; $display("FAIL inflight_data_ready: got %b expected 1", fetch_data_ready);
    end
    fetch_addr_ready = 1'b0;
    fetch_o_ready = 1'b0;
  endtask

  task automatic test_addr_stall();
    apply_reset();
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      checks++;
      if (fetch_addr_valid !== 1'b1 || fetch_addr !== BASE) begin
        failures++;
        $display("FAIL addr_stall c%0d: got valid=%b addr=%h expected valid=1 addr=%h",
                 cyc, fetch_addr_valid, fetch_addr, BASE);
      end
      tick();
    end
    fetch_addr_ready = 1'b1;
    tick();
    fetch_addr_ready = 1'b0;
    #1;
    checks++;
    if (fetch_addr !== BASE + 64'd4) begin
      failures++; $display("FAIL addr_stall_release: got %h expected %h", fetch_addr, BASE + 64'd4);
    end
  endtask

  task automatic test_output_stall();
    apply_reset();
    fetch_addr_ready = 1'b1;
    tick();                                   // c0: request BASE
    fetch_data_valid = 1'b1;
    fetch_data = 32'h100;
    #1;
    checks++;
    if (fetch_data_ready !== 1'b1) begin
      failures++; $display("FAIL ostall_first_ready: got %b expected 1", fetch_data_ready);
    end
    tick();                                   // c1: word for BASE loads
    fetch_data_valid = 1'b0;
    tick();                                   // c2: third request, two now in flight
    fetch_addr_ready = 1'b0;
    fetch_data_valid = 1'b1;
    fetch_data = 32'h200;
    for (int cyc = 3; cyc < 5; cyc++) begin
      #1;
      checks++;
      if (fetch_data_ready !== 1'b0 || fetch_o_valid !== 1'b1 ||
          fetch_o[95:32] !== BASE || fetch_o[31:0] !== 32'h100) begin
        failures++;
        $display("FAIL ostall_hold c%0d: got ready=%b valid=%b pc=%h instr=%h expected ready=0 valid=1 pc=%h instr=00000100",
                 cyc, fetch_data_ready, fetch_o_valid, fetch_o[95:32], fetch_o[31:0], BASE);
      end
      tick();
    end
    fetch_o_ready = 1'b1;
    #1;
    checks++;
    if (fetch_data_ready !== 1'b1) begin
      failures++; $display("FAIL ostall_release_ready: got %b expected 1", fetch_data_ready);
    end
    tick();
    fetch_data_valid = 1'b0;
    #1;
    checks++;
    if (fetch_o_valid !== 1'b1 || fetch_o[95:32] !== BASE + 64'd4 || fetch_o[31:0] !== 32'h200) begin
      failures++;
      $display("FAIL ostall_no_gap: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=00000200",
               fetch_o_valid, fetch_o[95:32], fetch_o[31:0], BASE + 64'd4);
    end
    tick();
    checks++;
    if (fetch_o_valid !== 1'b0) begin
      failures++; $display("FAIL ostall_drain: got valid=%b expected 0", fetch_o_valid);
    end
    fetch_o_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    fetch_addr_ready = 1'b1;
    tick();
    tick();
    tick();                                   // three requests in flight
    fetch_addr_ready = 1'b0;
    fetch_data_valid = 1'b1;
    fetch_data = 32'hAAAA;
    tick();                                   // one delivered, two remain in flight
    #1;
    checks++;
    if (fetch_o_valid !== 1'b1) begin
      failures++; $display("FAIL midrst_pending: got valid=%b expected 1", fetch_o_valid);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (fetch_addr_valid !== 1'b0 || fetch_data_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs: got addr_valid=%b data_ready=%b expected 0 0",
               fetch_addr_valid, fetch_data_ready);
    end
    tick();
    checks++;
    if (fetch_o_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_fo_cleared: got valid=%b expected 0", fetch_o_valid);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (fetch_addr_valid !== 1'b1 || fetch_addr !== BASE || fetch_data_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_restart: got valid=%b addr=%h data_ready=%b expected 1 %h 0",
               fetch_addr_valid, fetch_addr, fetch_data_ready, BASE);
    end
    tick();
    checks++;
    if (fetch_o_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_stale_data: got valid=%b expected 0", fetch_o_valid);
    end
    fetch_data_valid = 1'b0;
  endtask

  task automatic test_empty_data();
    apply_reset();
    fetch_data_valid = 1'b1;
    fetch_data = 32'hDEAD;
    #1;
    checks++;
    if (fetch_data_ready !== 1'b0) begin
      failures++; $display("FAIL empty_ready: got %b expected 0", fetch_data_ready);
    end
    tick();
    fetch_data_valid = 1'b0;
    #1;
    checks++;
    if (fetch_o_valid !== 1'b0 || fetch_addr !== BASE) begin
      failures++;
      $display("FAIL empty_no_effect: got valid=%b addr=%h expected 0 %h", fetch_o_valid, fetch_addr, BASE);
    end
  endtask

  task automatic test_pc_wrap();
    apply_reset();
    fetch_addr_ready = 1'b1;
    #1;
    checks++;
    if (w_addr_valid !== 1'b1 || w_addr !== WRAP_BOOT) begin
      failures++;
      $display("FAIL wrap_boot: got valid=%b addr=%h expected 1 %h", w_addr_valid, w_addr, WRAP_BOOT);
    end
    tick();
    fetch_data_valid = 1'b1;
    fetch_data = 32'h55;
    #1;
    checks++;
    if (w_addr !== 64'd0) begin
      failures++; $display("FAIL wrap_zero: got %h expected 0", w_addr);
    end
    tick();
    fetch_data_valid = 1'b0;
    fetch_addr_ready = 1'b0;
    fetch_o_ready = 1'b1;
    #1;
    checks++;
    if (w_fo_valid !== 1'b1 || w_fo[95:32] !== WRAP_BOOT || w_fo[31:0] !== 32'h55 ||
        w_addr !== 64'd4 || w_data_ready !== 1'b1) begin
      failures++;
      $display("FAIL wrap_deliver: got valid=%b pc=%h instr=%h addr=%h ready=%b expected 1 %h 00000055 4 1",
               w_fo_valid, w_fo[95:32], w_fo[31:0], w_addr, w_data_ready, WRAP_BOOT);
    end
    fetch_o_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_no_response();
    test_addr_stall();
    test_output_stall();
    test_mid_reset();
    test_empty_data();
    test_pc_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
